gpr_wb_sched: RTL and testbench

GPR_WB_SCHED -- requirements
Module: gpr_wb_sched

---
 rtl/gpr_wb_sched.sv | 157 +++++++++++++++
 tb/tb_gpr_wb_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_sched.sv
// Two-source register-file writeback scheduler with a pending scoreboard.
// Define GPR_WB_BYPASS_EN to drive the forwarding outputs from the write port.
module gpr_wb_sched #(
   parameter int FIXED_PRI = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        s0_valid,
   output logic        s0_ready,
   input  logic [4:0]  s0_addr,
   input  logic [31:0] s0_data,
   input  logic        s1_valid,
   output logic        s1_ready,
   input  logic [4:0]  s1_addr,
   input  logic [31:0] s1_data,
   output logic        we,
   output logic [4:0]  wa,
   output logic [31:0] wd,
   input  logic        set_v,
   input  logic [4:0]  set_a,
   input  logic [4:0]  q1,
   input  logic [4:0]  q2,
   output logic        pend1,
   output logic        pend2,
   output logic        fwd1_v,
   output logic        fwd2_v,
   output logic [31:0] fwd1_d,
   output logic [31:0] fwd2_d
);

   logic        b0_v_q, b0_v_d;
   logic [4:0]  b0_a_q, b0_a_d;
   logic [31:0] b0_d_q, b0_d_d;
   logic        b1_v_q, b1_v_d;
   logic [4:0]  b1_a_q, b1_a_d;
   logic [31:0] b1_d_q, b1_d_d;
   logic        we_q, we_d;
   logic [4:0]  wa_q, wa_d;
   logic [31:0] wd_q, wd_d;
   logic [31:0] pend_q, pend_d;
   // 1 = source 1 was granted last, so source 0 wins the next tie
   logic        last_q, last_d;

   logic        g0, g1, acc0, acc1, issue;
   logic [4:0]  ga;
   logic [31:0] gd;

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (b0_v_q && b1_v_q) begin
         if (FIXED_PRI != 0) g1 = 1'b1;
         else if (last_q)    g0 = 1'b1;
         else                g1 = 1'b1;
      end else if (b0_v_q) begin
         g0 = 1'b1;
      end else if (b1_v_q) begin
         g1 = 1'b1;
      end
   end

   assign s0_ready = !reset && (!b0_v_q || g0);
   assign s1_ready = !reset && (!b1_v_q || g1);
   assign acc0     = s0_valid && s0_ready;
   assign acc1     = s1_valid && s1_ready;

   assign ga    = g1 ? b1_a_q : b0_a_q;
   assign gd    = g1 ? b1_d_q : b0_d_q;
   assign issue = (g0 || g1) && (ga != 5'd0);

   always_comb begin
      b0_v_d = b0_v_q;
      b0_a_d = b0_a_q;
      b0_d_d = b0_d_q;
      b1_v_d = b1_v_q;
      b1_a_d = b1_a_q;
      b1_d_d = b1_d_q;
      if (g0) b0_v_d = 1'b0;
      if (g1) b1_v_d = 1'b0;
      if (acc0) begin
         b0_v_d = 1'b1;
         b0_a_d = s0_addr;
         b0_d_d = s0_data;
      end
      if (acc1) begin
         b1_v_d = 1'b1;
         b1_a_d = s1_addr;
         b1_d_d = s1_data;
      end
   end

   always_comb begin
      we_d   = issue;
      wa_d   = issue ? ga : wa_q;
      wd_d   = issue ? gd : wd_q;
      last_d = (g0 || g1) ? g1 : last_q;
   end

   // set is applied after clear so a same-register collision stays pending
   always_comb begin
      pend_d = pend_q;
      if (we_q)
         pend_d[wa_q] = 1'b0;
      if (set_v && (set_a != 5'd0))
         pend_d[set_a] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         b0_v_q <= 1'b0;
         b0_a_q <= '0;
         b0_d_q <= '0;
         b1_v_q <= 1'b0;
         b1_a_q <= '0;
         b1_d_q <= '0;
         we_q   <= 1'b0;
         wa_q   <= '0;
         wd_q   <= '0;
         pend_q <= '0;
         last_q <= 1'b1;
      end else begin
         b0_v_q <= b0_v_d;
         b0_a_q <= b0_a_d;
         b0_d_q <= b0_d_d;
         b1_v_q <= b1_v_d;
         b1_a_q <= b1_a_d;
         b1_d_q <= b1_d_d;
         we_q   <= we_d;
         wa_q   <= wa_d;
         wd_q   <= wd_d;
         pend_q <= pend_d;
         last_q <= last_d;
      end
   end

   assign we = we_q;
   assign wa = wa_q;
   assign wd = wd_q;

`ifdef GPR_WB_BYPASS_EN
   assign fwd1_v = we_q && (wa_q == q1) && (q1 != 5'd0);
   assign fwd2_v = we_q && (wa_q == q2) && (q2 != 5'd0);
   assign fwd1_d = wd_q;
   assign fwd2_d = wd_q;
   assign pend1  = pend_q[q1] && !fwd1_v;
   assign pend2  = pend_q[q2] && !fwd2_v;
`else
   assign fwd1_v = 1'b0;
   assign fwd2_v = 1'b0;
   assign fwd1_d = '0;
   assign fwd2_d = '0;
   assign pend1  = pend_q[q1];
   assign pend2  = pend_q[q2];
`endif

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Directed bench for gpr_wb_sched: u_rr uses round-robin, u_fp fixed priority.
module tb_gpr_wb_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic        s0_valid, s1_valid, set_v;
   logic [4:0]  s0_addr, s1_addr, set_a, q1, q2;
   logic [31:0] s0_data, s1_data;

   logic        s0_ready, s1_ready, we, pend1, pend2, fwd1_v, fwd2_v;
   logic [4:0]  wa;
   logic [31:0] wd, fwd1_d, fwd2_d;

   logic        f_s0_ready, f_s1_ready, f_we, f_pend1, f_pend2;
   logic        f_fwd1_v, f_fwd2_v;
   logic [4:0]  f_wa;
   logic [31:0] f_wd, f_fwd1_d, f_fwd2_d;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gpr_wb_sched #(.FIXED_PRI(0)) u_rr (
      .clk(clk), .reset(reset),
      .s0_valid(s0_valid), .s0_ready(s0_ready),
      .s0_addr(s0_addr), .s0_data(s0_data),
      .s1_valid(s1_valid), .s1_ready(s1_ready),
      .s1_addr(s1_addr), .s1_data(s1_data),
      .we(we), .wa(wa), .wd(wd),
      .set_v(set_v), .set_a(set_a), .q1(q1), .q2(q2),
      .pend1(pend1), .pend2(pend2),
      .fwd1_v(fwd1_v), .fwd2_v(fwd2_v),
      .fwd1_d(fwd1_d), .fwd2_d(fwd2_d)
   );

   gpr_wb_sched #(.FIXED_PRI(1)) u_fp (
      .clk(clk), .reset(reset),
      .s0_valid(s0_valid), .s0_ready(f_s0_ready),
      .s0_addr(s0_addr), .s0_data(s0_data),
      .s1_valid(s1_valid), .s1_ready(f_s1_ready),
      .s1_addr(s1_addr), .s1_data(s1_data),
      .we(f_we), .wa(f_wa), .wd(f_wd),
      .set_v(set_v), .set_a(set_a), .q1(q1), .q2(q2),
      .pend1(f_pend1), .pend2(f_pend2),
      .fwd1_v(f_fwd1_v), .fwd2_v(f_fwd2_v),
      .fwd1_d(f_fwd1_d), .fwd2_d(f_fwd2_d)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam int BYP =
`ifdef GPR_WB_BYPASS_EN
      1;
`else
      0;
`endif

   int exp_rr_wa [7] = '{0, 0, 1, 2, 1, 2, 1};
   int exp_fp_wa [7] = '{0, 0, 2, 2, 2, 2, 1};

   initial begin
      reset = 1'b1;
      s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
      s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
      set_v = 1'b0; set_a = '0; q1 = '0; q2 = '0;
      tick();
      tick();
      chk("rst_we", {31'd0, we}, 32'd0);
      chk("rst_wa", {27'd0, wa}, 32'd0);
      chk("rst_wd", wd, 32'd0);
      chk("rst_rdy_low", {31'd0, s0_ready}, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_rdy0", {31'd0, s0_ready}, 32'd1);
      chk("rst_rdy1", {31'd0, s1_ready}, 32'd1);

      // single write, two-edge latency
      s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'hDEADBEEF;
      tick();
      s0_valid = 1'b0;
      chk("lat_n", {31'd0, we}, 32'd0);
      tick();
      chk("lat_we", {31'd0, we}, 32'd1);
      chk("lat_wa", {27'd0, wa}, 32'd5);
      chk("lat_wd", wd, 32'hDEADBEEF);
      tick();
      chk("pulse_we", {31'd0, we}, 32'd0);
      chk("hold_wa", {27'd0, wa}, 32'd5);
      chk("hold_wd", wd, 32'hDEADBEEF);

      // both sources streaming
      reset = 1'b1;
      tick();
      reset = 1'b0;
      s0_valid = 1'b1; s0_addr = 5'd1; s0_data = 32'h100;
      s1_valid = 1'b1; s1_addr = 5'd2; s1_data = 32'h200;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 4) begin
            s0_valid = 1'b0;
            s1_valid = 1'b0;
         end
         if (i == 1) begin
            chk("rr_rdy0", {31'd0, s0_ready}, 32'd1);
            chk("rr_rdy1", {31'd0, s1_ready}, 32'd0);
            chk("fp_rdy1", {31'd0, f_s1_ready}, 32'd1);
         end
         if (i <= 3)
            chk($sformatf("fp_stall%0d", i), {31'd0, f_s0_ready}, 32'd0);
         if (i >= 2 && i <= 6) begin
            chk($sformatf("rr_we%0d", i), {31'd0, we}, 32'd1);
            chk($sformatf("rr_wa%0d", i), {27'd0, wa}, exp_rr_wa[i]);
            chk($sformatf("fp_we%0d", i), {31'd0, f_we}, 32'd1);
            chk($sformatf("fp_wa%0d", i), {27'd0, f_wa}, exp_fp_wa[i]);
         end
         if (i == 2)
            chk("rr_wd2", wd, 32'h100);
         if (i == 7) begin
            chk("rr_idle", {31'd0, we}, 32'd0);
            chk("fp_idle", {31'd0, f_we}, 32'd0);
         end
      end

      // scoreboard set / clear
      set_v = 1'b1; set_a = 5'd7; q1 = 5'd7;
      tick();
      set_v = 1'b0;
      chk("sb_set", {31'd0, pend1}, 32'd1);
      s0_valid = 1'b1; s0_addr = 5'd7; s0_data = 32'h77;
      tick();
      s0_valid = 1'b0;
      chk("sb_wait", {31'd0, pend1}, 32'd1);
      tick();
      chk("sb_we", {31'd0, we}, 32'd1);
      chk("sb_wa", {27'd0, wa}, 32'd7);
      chk("sb_issue", {31'd0, pend1}, BYP ? 32'd0 : 32'd1);
      tick();
      chk("sb_clr", {31'd0, pend1}, 32'd0);
      s0_valid = 1'b1;
      tick();
      s0_valid = 1'b0;
      tick();
      chk("sb_we2", {31'd0, we}, 32'd1);
      set_v = 1'b1; set_a = 5'd7;
      tick();
      set_v = 1'b0;
      chk("sb_setwin", {31'd0, pend1}, 32'd1);
      set_v = 1'b1; set_a = 5'd0; q2 = 5'd0;
      tick();
      set_v = 1'b0;
      #1;
      chk("sb_zero", {31'd0, pend2}, 32'd0);

      // address 0 discarded
      s1_valid = 1'b1; s1_addr = 5'd0; s1_data = 32'h1234;
      tick();
      s1_valid = 1'b0;
      chk("z_rdy_g", {31'd0, s1_ready}, 32'd1);
      tick();
      chk("z_we", {31'd0, we}, 32'd0);
      chk("z_rdy", {31'd0, s1_ready}, 32'd1);
      chk("z_pend", {31'd0, pend1}, 32'd1);
      chk("z_wa", {27'd0, wa}, 32'd7);

      // reset with both buffers full
      s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h3;
      s1_valid = 1'b1; s1_addr = 5'd4; s1_data = 32'h4;
      tick();
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      chk("full_rdy1", {31'd0, s1_ready}, 32'd0);
      reset = 1'b1;
      #1;
      chk("rst_rdy", {31'd0, s0_ready}, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("mr_we", {31'd0, we}, 32'd0);
      chk("mr_rdy0", {31'd0, s0_ready}, 32'd1);
      chk("mr_rdy1", {31'd0, s1_ready}, 32'd1);
      chk("mr_pend", {31'd0, pend1}, 32'd0);
      tick();
      chk("mr_drop", {31'd0, we}, 32'd0);

      // forwarding
      set_v = 1'b1; set_a = 5'd9; q2 = 5'd9;
      tick();
      set_v = 1'b0;
      s0_valid = 1'b1; s0_addr = 5'd9; s0_data = 32'hCAFE0001;
      tick();
      s0_valid = 1'b0;
      tick();
      chk("fw_we", {31'd0, we}, 32'd1);
      chk("fw_v2", {31'd0, fwd2_v}, BYP ? 32'd1 : 32'd0);
      chk("fw_d2", fwd2_d, BYP ? 32'hCAFE0001 : 32'd0);
      chk("fw_p2", {31'd0, pend2}, BYP ? 32'd0 : 32'd1);
      chk("fw_v1", {31'd0, fwd1_v}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
